sr595_chain_driver: RTL and testbench
=====================================

Name: sr595_chain_driver

Overview:
- Parametrised serial loader for daisy-chained 74HC595-style shift registers driving the LED cube planes.
- Accepts a parallel word per channel on a start/busy/done handshake and shifts all channels in parallel on a shared shift clock.
- Then issues one storage-latch pulse.
- Adds programmable shift-clock rate, latch width, bit order and multi-channel output.
- Sits between the frame/plane sequencer (which supplies ROM data) and the top-level pins.

Parameters:
- DATA_WIDTH, 56, bits shifted per channel per load (>=1).
- CHANNELS, 1, number of independent DS lines sharing shcp/stcp (>=1).
- CLK_DIV, 1, clk cycles per shcp half-period (>=1).
- LATCH_CYCLES, 1, clk cycles stcp is held high (>=1).
- MSB_FIRST, 0, 0 = bit 0 shifted first; 1 = bit DATA_WIDTH-1 shifted first.

Ports:
- clk  in  1  system clock, all logic on posedge.
- reset  in  1  synchronous, active-high.
- start  in  1  request a load; sampled only when busy=0.
- data  in  CHANNELS*DATA_WIDTH  channel c bit i = data[c*DATA_WIDTH+i]; captured on accepted start.
- busy  out  1  high while a load is in progress.
- done  out  1  one-cycle pulse when a load completes.
- ds  out  CHANNELS  serial data, one bit per channel.
- shcp  out  1  shift clock to all chains.
- stcp  out  1  storage latch clock.
- mr_n  out  1  active-low chain master reset.

Behaviour:
- Reset: synchronous, active-high; clock clk.
- Reset values: ds=0, shcp=0, stcp=0, mr_n=0, busy=0, done=0, state=IDLE, bit counter=0.
- mr_n returns to 1 on the first clk edge after reset deasserts.
- All outputs are registered.
- States: IDLE, SETUP, SHIFT, LATCH, DONE.
- IDLE: busy=0, shcp=0, stcp=0. On start=1, capture data into a shadow register, clear the bit counter, go to SETUP.
- SETUP: busy=1, shcp=0. ds[c] = shadow bit for the current index. Hold for CLK_DIV cycles, then go to SHIFT.
- SHIFT: shcp=1 and ds is held stable for CLK_DIV cycles (the rising edge is mid-eye).
  - If counter = DATA_WIDTH-1, go to LATCH.
  - Otherwise, increment the counter and go to SETUP.
- Bit index: counter when MSB_FIRST=0; DATA_WIDTH-1-counter when MSB_FIRST=1.
- Counter width is clog2(DATA_WIDTH+1). A separate divider counter of clog2(max(CLK_DIV,LATCH_CYCLES)+1) bits serves both the shcp half-period and the latch pulse width.
- LATCH: shcp=0, stcp=1 for LATCH_CYCLES, then go to DONE.
- DONE: stcp=0, busy=0, done=1 for exactly one cycle, then go to IDLE.
  - A start sampled in DONE is accepted (back-to-back), going directly to SETUP.
- Latency: start accepted at cycle 0 means busy is high for cycles 1..(2*CLK_DIV*DATA_WIDTH + LATCH_CYCLES). done is asserted in the following cycle.
- Exactly DATA_WIDTH shcp rising edges and one stcp rising edge occur per load.
- start while busy=1 is ignored. No queuing; the shadow data is unchanged.
- data changes after acceptance have no effect on the load in progress.
- Reset mid-load: the load is aborted with no stcp pulse. mr_n=0 for the reset cycle(s), clearing the chain. The latched outputs keep their prior contents. done is not asserted.
- Bits are never dropped or duplicated at the DATA_WIDTH boundary; the counter does not wrap within a load.

Optional Feature:
- Macro SR595_OE_BLANK_EN.
- When defined, adds output port oe_n (1 bit, active-low output enable).
  - oe_n=1 (blanked) from LATCH entry through the DONE cycle; 0 otherwise.
  - Reset value is 1; oe_n goes to 0 the cycle after reset deasserts.
  - This suppresses ghosting during plane switching.
- When undefined, the port and its logic are absent; the pin is tied externally.

Test Plan:
- Basic load: DATA_WIDTH=8, CHANNELS=1, CLK_DIV=1, LATCH_CYCLES=1, MSB_FIRST=0, data=8'hA5, start at cycle 0.
  - ds at the 8 shcp rising edges = 1,0,1,0,0,1,0,1.
  - stcp high in cycle 17 only; busy high for cycles 1-17; done in cycle 18.
- Divided clock: same setup with CLK_DIV=3, LATCH_CYCLES=2, MSB_FIRST=1, data=8'h81.
  - shcp period is 6 cycles; ds sequence = 1,0,0,0,0,0,0,1.
  - stcp high for 2 cycles; done 51 cycles after start.
- Multi-channel: CHANNELS=2, DATA_WIDTH=4, data={4'hF,4'h0}.
  - ds[1]=1 and ds[0]=0 at all 4 shcp rising edges.
- Busy/back-to-back:
  - start held during a load: exactly one load occurs.
  - start pulsed in the done cycle with data=8'h3C: the second load begins in the next cycle (SETUP) with no IDLE gap, and shifts 0,0,1,1,1,1,0,0.
- Reset mid-load: assert reset at cycle 7 of an 8-bit load.
  - mr_n=0 and shcp=0 in the next cycle; no stcp or done pulse.
  - The next start performs a full clean load.
- SR595_OE_BLANK_EN defined: oe_n=1 during the LATCH and DONE cycles and during reset; 0 otherwise.

Source files
------------

// File: rtl/sr595_chain_driver_if.sv
// Handshake/bus bundle between the plane sequencer and the 74HC595 chain driver.
// The sequencer side (master) requests loads; the driver side (slave) reports progress.
interface sr595_chain_driver_if #(
  parameter int unsigned DATA_WIDTH = 56,
  parameter int unsigned CHANNELS   = 1
);
  logic                           start;
  logic [CHANNELS*DATA_WIDTH-1:0] data;
  logic                           busy;
  logic                           done;

  modport master (output start, output data, input busy, input done);
  modport slave  (input start, input data, output busy, output done);
endinterface

// File: rtl/sr595_chain_driver.sv
// Serial loader for daisy-chained 74HC595-style shift registers.
// Captures one word per channel, shifts all channels in parallel on a shared
// shcp, then issues a single stcp latch pulse. All outputs are registered.
// Optional feature: define SR595_OE_BLANK_EN to add the active-low oe_n port,
// which blanks the outputs from latch entry through the done cycle.
module sr595_chain_driver #(
  parameter int unsigned DATA_WIDTH   = 56,
  parameter int unsigned CHANNELS     = 1,
  parameter int unsigned CLK_DIV      = 1,
  parameter int unsigned LATCH_CYCLES = 1,
  parameter int unsigned MSB_FIRST    = 0
) (
  input  logic                clk,
  input  logic                reset,
  sr595_chain_driver_if.slave bus,
  output logic [CHANNELS-1:0] ds,
  output logic                shcp,
  output logic                stcp,
  output logic                mr_n
`ifdef SR595_OE_BLANK_EN
  ,
  output logic                oe_n
`endif
);

  localparam int unsigned CNT_W   = $clog2(DATA_WIDTH + 1);
  localparam int unsigned DIV_MAX = (CLK_DIV > LATCH_CYCLES) ? CLK_DIV : LATCH_CYCLES;
  localparam int unsigned DIV_W   = $clog2(DIV_MAX + 1);

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] LAT_LAST = DIV_W'(LATCH_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_SHIFT,
    S_LATCH,
    S_DONE
  } state_t;

  state_t                         state_q;
  logic [CHANNELS*DATA_WIDTH-1:0] shadow_q;
  logic [CNT_W-1:0]               cnt_q;
  logic [CNT_W-1:0]               cnt_d;
  logic [DIV_W-1:0]               div_q;
  logic [DIV_W-1:0]               div_d;
  logic [CHANNELS-1:0]            ds_q;
  logic [CHANNELS-1:0]            ds_first_d;
  logic [CHANNELS-1:0]            ds_next_d;
  logic                           shcp_q;
  logic                           stcp_q;
  logic                           mr_n_q;
  logic                           busy_q;
  logic                           done_q;
`ifdef SR595_OE_BLANK_EN
  logic                           oe_n_q;
`endif

  // Gather the bit at the current shift position from every channel.
  function automatic logic [CHANNELS-1:0] pick_bits(
    input logic [CHANNELS*DATA_WIDTH-1:0] word,
    input logic [CNT_W-1:0]               cnt
  );
    int unsigned         idx;
    logic [CHANNELS-1:0] bits;
    if (MSB_FIRST != 0) idx = DATA_WIDTH - 1 - 32'(cnt);
    else                idx = 32'(cnt);
    bits = '0;
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      bits[c] = word[c*DATA_WIDTH + idx];
    end
    return bits;
  endfunction

  // Next counter values and the serial bits for the first and following positions.
  always_comb begin
    cnt_d      = cnt_q + 1'b1;
    div_d      = div_q + 1'b1;
    ds_first_d = pick_bits(bus.data, '0);
    ds_next_d  = pick_bits(shadow_q, cnt_d);
  end

  // Load sequencer; every output is assigned alongside the state it belongs to,
  // so each pin already carries the value of the state being entered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      shadow_q <= '0;
      cnt_q    <= '0;
      div_q    <= '0;
      ds_q     <= '0;
      shcp_q   <= 1'b0;
      stcp_q   <= 1'b0;
      mr_n_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef SR595_OE_BLANK_EN
      oe_n_q   <= 1'b1;
`endif
    end else begin
      mr_n_q <= 1'b1;
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE, S_DONE: begin
          shcp_q <= 1'b0;
          stcp_q <= 1'b0;
`ifdef SR595_OE_BLANK_EN
          oe_n_q <= 1'b0;
`endif
          if (bus.start) begin
            shadow_q <= bus.data;
            cnt_q    <= '0;
            div_q    <= '0;
            ds_q     <= ds_first_d;
            busy_q   <= 1'b1;
            state_q  <= S_SETUP;
          end else begin
            busy_q   <= 1'b0;
            state_q  <= S_IDLE;
          end
        end
        S_SETUP: begin
          if (div_q == DIV_LAST) begin
            div_q   <= '0;
            shcp_q  <= 1'b1;
            state_q <= S_SHIFT;
          end else begin
            div_q   <= div_d;
          end
        end
        S_SHIFT: begin
          if (div_q == DIV_LAST) begin
            div_q  <= '0;
            shcp_q <= 1'b0;
            if (cnt_q == LAST_BIT) begin
              stcp_q  <= 1'b1;
`ifdef SR595_OE_BLANK_EN
              oe_n_q  <= 1'b1;
`endif
              state_q <= S_LATCH;
            end else begin
              cnt_q   <= cnt_d;
              ds_q    <= ds_next_d;
              state_q <= S_SETUP;
            end
          end else begin
            div_q <= div_d;
          end
        end
        S_LATCH: begin
          if (div_q == LAT_LAST) begin
            div_q   <= '0;
            stcp_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            div_q <= div_d;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ds       = ds_q;
  assign shcp     = shcp_q;
  assign stcp     = stcp_q;
  assign mr_n     = mr_n_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
`ifdef SR595_OE_BLANK_EN
  assign oe_n     = oe_n_q;
`endif

endmodule

// File: tb/tb_sr595_chain_driver.sv
// Directed bench for sr595_chain_driver: three configurations side by side
// (basic, divided/MSB-first, two-channel) sharing one clock and reset.
module tb_sr595_chain_driver;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  sr595_chain_driver_if #(.DATA_WIDTH(8), .CHANNELS(1)) bus_a ();
  sr595_chain_driver_if #(.DATA_WIDTH(8), .CHANNELS(1)) bus_b ();
  sr595_chain_driver_if #(.DATA_WIDTH(4), .CHANNELS(2)) bus_c ();

  logic [0:0] ds_a, ds_b;
  logic [1:0] ds_c;
  logic shcp_a, stcp_a, mr_n_a;
  logic shcp_b, stcp_b, mr_n_b;
  logic shcp_c, stcp_c, mr_n_c;
`ifdef SR595_OE_BLANK_EN
  logic oe_a, oe_b, oe_c;
`endif

  sr595_chain_driver #(.DATA_WIDTH(8), .CHANNELS(1), .CLK_DIV(1), .LATCH_CYCLES(1), .MSB_FIRST(0)) dut_a (
    .clk(clk), .reset(reset), .bus(bus_a), .ds(ds_a), .shcp(shcp_a), .stcp(stcp_a), .mr_n(mr_n_a)
`ifdef SR595_OE_BLANK_EN
    , .oe_n(oe_a)
`endif
  );
  sr595_chain_driver #(.DATA_WIDTH(8), .CHANNELS(1), .CLK_DIV(3), .LATCH_CYCLES(2), .MSB_FIRST(1)) dut_b (
    .clk(clk), .reset(reset), .bus(bus_b), .ds(ds_b), .shcp(shcp_b), .stcp(stcp_b), .mr_n(mr_n_b)
`ifdef SR595_OE_BLANK_EN
    , .oe_n(oe_b)
`endif
  );
  sr595_chain_driver #(.DATA_WIDTH(4), .CHANNELS(2), .CLK_DIV(1), .LATCH_CYCLES(1), .MSB_FIRST(0)) dut_c (
    .clk(clk), .reset(reset), .bus(bus_c), .ds(ds_c), .shcp(shcp_c), .stcp(stcp_c), .mr_n(mr_n_c)
`ifdef SR595_OE_BLANK_EN
    , .oe_n(oe_c)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_start(input int which, input logic v);
    case (which)
      0: bus_a.start = v;
      1: bus_b.start = v;
      default: bus_c.start = v;
    endcase
  endtask

  task automatic set_data(input int which, input logic [63:0] d);
    case (which)
      0: bus_a.data = d[7:0];
      1: bus_b.data = d[7:0];
      default: bus_c.data = d[7:0];
    endcase
  endtask

  task automatic sample(input int which, output logic b, output logic s, output logic dn,
                        output logic sh, output logic [1:0] dsv, output logic oe);
    oe = 1'b0;
    case (which)
      0: begin b = bus_a.busy; s = stcp_a; dn = bus_a.done; sh = shcp_a; dsv = {1'b0, ds_a};
`ifdef SR595_OE_BLANK_EN
        oe = oe_a;
`endif
      end
      1: begin b = bus_b.busy; s = stcp_b; dn = bus_b.done; sh = shcp_b; dsv = {1'b0, ds_b};
`ifdef SR595_OE_BLANK_EN
        oe = oe_b;
`endif
      end
      default: begin b = bus_c.busy; s = stcp_c; dn = bus_c.done; sh = shcp_c; dsv = ds_c;
`ifdef SR595_OE_BLANK_EN
        oe = oe_c;
`endif
      end
    endcase
  endtask

  // Starts a load in the current cycle (cycle 0) and records cycles 1..ncyc.
  // start stays high for cycles < hold and in cycle p2 (second request, data d2);
  // data is scrambled in cycle 2 to show the captured word is unaffected.
  task automatic capture(input int which, input logic [63:0] d1, input int hold,
                         input int p2, input logic [63:0] d2, input int ncyc,
                         output logic [63:0] bm, output logic [63:0] sm,
                         output logic [63:0] dm, output logic [63:0] om,
                         output logic [15:0] s0, output logic [15:0] s1,
                         output int ne, output int first_e, output int last_e);
    logic b, s, dn, sh, oe, prev;
    logic [1:0] dsv;
    bm = '0; sm = '0; dm = '0; om = '0; s0 = '0; s1 = '0;
    ne = 0; first_e = -1; last_e = -1; prev = 1'b0;
    set_data(which, d1);
    set_start(which, 1'b1);
    for (int c = 1; c <= ncyc; c++) begin
      tick();
      sample(which, b, s, dn, sh, dsv, oe);
      bm[c] = b; sm[c] = s; dm[c] = dn; om[c] = oe;
      if (sh && !prev) begin
        if (ne < 16) begin
          s0[ne] = dsv[0];
          s1[ne] = dsv[1];
        end
        if (ne == 0) first_e = c;
        last_e = c;
        ne++;
      end
      prev = sh;
      set_start(which, (c < hold) || (c == p2));
      if (c == 2) set_data(which, ~d1);
      if (c == p2) set_data(which, d2);
    end
    set_start(which, 1'b0);
  endtask

  logic [63:0] bm, sm, dm, om;
  logic [15:0] s0, s1;
  int ne, fe, le;
  int stcp_seen, done_seen;

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    bus_a.start = 1'b0; bus_b.start = 1'b0; bus_c.start = 1'b0;
    bus_a.data = '0; bus_b.data = '0; bus_c.data = '0;
    repeat (3) tick();

    // Reset state: ds, shcp, stcp, mr_n, busy, done all low.
    chk("rst_a", {62'(ds_a), shcp_a, stcp_a, mr_n_a, bus_a.busy, bus_a.done}, 64'h0);
    chk("rst_b", {62'(ds_b), shcp_b, stcp_b, mr_n_b, bus_b.busy, bus_b.done}, 64'h0);
    chk("rst_c", {62'(ds_c), shcp_c, stcp_c, mr_n_c, bus_c.busy, bus_c.done}, 64'h0);
`ifdef SR595_OE_BLANK_EN
    chk("rst_oe", {61'h0, oe_a, oe_b, oe_c}, 64'h7);
`endif

    reset = 1'b0;
    tick();
    chk("mr_n_release", {61'h0, mr_n_a, mr_n_b, mr_n_c}, 64'h7);
    chk("idle_busy", {61'h0, bus_a.busy, bus_b.busy, bus_c.busy}, 64'h0);
`ifdef SR595_OE_BLANK_EN
    chk("oe_release", {61'h0, oe_a, oe_b, oe_c}, 64'h0);
`endif

    // Basic load, 0xA5 LSB first.
    capture(0, 64'hA5, 1, -1, 64'h0, 24, bm, sm, dm, om, s0, s1, ne, fe, le);
    chk("basic_ds", 64'(s0), 64'h00A5);
    chk("basic_edges", 64'(ne), 64'd8);
    chk("basic_first_edge", 64'(fe), 64'd2);
    chk("basic_last_edge", 64'(le), 64'd16);
    chk("basic_busy", bm, 64'h0000_0000_0003_FFFE);
    chk("basic_stcp", sm, 64'h0000_0000_0002_0000);
    chk("basic_done", dm, 64'h0000_0000_0004_0000);
`ifdef SR595_OE_BLANK_EN
    chk("basic_oe", om, 64'h0000_0000_0006_0000);
`endif

    // Divided clock, MSB first, 0x81.
    capture(1, 64'h81, 1, -1, 64'h0, 56, bm, sm, dm, om, s0, s1, ne, fe, le);
    chk("div_ds", 64'(s0), 64'h0081);
    chk("div_edges", 64'(ne), 64'd8);
    chk("div_first_edge", 64'(fe), 64'd4);
    chk("div_last_edge", 64'(le), 64'd46);
    chk("div_busy", bm, 64'h0007_FFFF_FFFF_FFFE);
    chk("div_stcp", sm, 64'h0006_0000_0000_0000);
    chk("div_done", dm, 64'h0008_0000_0000_0000);

    // Two channels: channel 1 = 4'hF, channel 0 = 4'h0.
    capture(2, 64'hF0, 1, -1, 64'h0, 16, bm, sm, dm, om, s0, s1, ne, fe, le);
    chk("mc_ds0", 64'(s0), 64'h0);
    chk("mc_ds1", 64'(s1), 64'hF);
    chk("mc_edges", 64'(ne), 64'd4);
    chk("mc_busy", bm, 64'h3FE);
    chk("mc_stcp", sm, 64'h200);
    chk("mc_done", dm, 64'h400);

    // start held high through the load: exactly one load.
    capture(0, 64'hA5, 17, -1, 64'h0, 40, bm, sm, dm, om, s0, s1, ne, fe, le);
    chk("held_edges", 64'(ne), 64'd8);
    chk("held_ds", 64'(s0), 64'h00A5);
    chk("held_stcp", sm, 64'h0000_0000_0002_0000);
    chk("held_done", dm, 64'h0000_0000_0004_0000);

    // Back-to-back: second start (0x3C) pulsed in the done cycle.
    capture(0, 64'hA5, 1, 18, 64'h3C, 44, bm, sm, dm, om, s0, s1, ne, fe, le);
    chk("b2b_edges", 64'(ne), 64'd16);
    chk("b2b_ds", 64'(s0), 64'h3CA5);
    chk("b2b_busy", bm, 64'h0000_000F_FFFB_FFFE);
    chk("b2b_stcp", sm, 64'h0000_0008_0002_0000);
    chk("b2b_done", dm, 64'h0000_0010_0004_0000);

    // Reset asserted in cycle 7 of a load.
    bus_a.data = 8'hA5;
    bus_a.start = 1'b1;
    tick();
    bus_a.start = 1'b0;
    repeat (6) tick();
    reset = 1'b1;
    tick();
    chk("midrst_mr_n", 64'(mr_n_a), 64'h0);
    chk("midrst_shcp", 64'(shcp_a), 64'h0);
    chk("midrst_busy_stcp_done", {61'h0, bus_a.busy, stcp_a, bus_a.done}, 64'h0);
`ifdef SR595_OE_BLANK_EN
    chk("midrst_oe", 64'(oe_a), 64'h1);
`endif
    reset = 1'b0;
    stcp_seen = 0;
    done_seen = 0;
    for (int c = 0; c < 30; c++) begin
      tick();
      if (stcp_a) stcp_seen++;
      if (bus_a.done) done_seen++;
    end
    chk("midrst_mr_n_back", 64'(mr_n_a), 64'h1);
    chk("midrst_no_stcp", 64'(stcp_seen), 64'h0);
    chk("midrst_no_done", 64'(done_seen), 64'h0);

    // Clean load after the aborted one.
    capture(0, 64'h5A, 1, -1, 64'h0, 24, bm, sm, dm, om, s0, s1, ne, fe, le);
    chk("post_rst_ds", 64'(s0), 64'h005A);
    chk("post_rst_edges", 64'(ne), 64'd8);
    chk("post_rst_busy", bm, 64'h0000_0000_0003_FFFE);
    chk("post_rst_stcp", sm, 64'h0000_0000_0002_0000);
    chk("post_rst_done", dm, 64'h0000_0000_0004_0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
